// File: rtl/pu_riscv_pkg.sv
// Shared AHB3-Lite encodings and write-buffer entry layout for the pu_riscv write drain.
// An entry is packed as {adr, size, data} with data in the least significant bits.
package pu_riscv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int ENTRY_SIZE_W   = 3;
    localparam int ENTRY_DATA_LSB = 0;

    function automatic int entry_size_lsb(input int xlen);
        return ENTRY_DATA_LSB + xlen;
    endfunction

    function automatic int entry_adr_lsb(input int xlen);
        return ENTRY_DATA_LSB + xlen + ENTRY_SIZE_W;
    endfunction

    function automatic int entry_width(input int plen, input int xlen);
        return plen + ENTRY_SIZE_W + xlen;
    endfunction

endpackage

// File: rtl/pu_riscv_wb_drain.sv
// Drains write-buffer entries onto an AHB3-Lite bus as single write transfers.
// Define PU_RISCV_WB_DRAIN_PIPELINE_EN to overlap the next address phase with the current data phase.
module pu_riscv_wb_drain
    import pu_riscv_pkg::*;
#(
    parameter int         PLEN      = 32,
    parameter int         XLEN      = 64,
    parameter logic [3:0] HPROT_VAL = 4'b0001
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clr_i,

    input  logic [PLEN+ENTRY_SIZE_W+XLEN-1:0]    q_i,
    input  logic                                 q_empty_i,
    output logic                                 q_re_o,

    output logic                                 HSEL,
    output logic [PLEN-1:0]                      HADDR,
    output logic [XLEN-1:0]                      HWDATA,
    output logic                                 HWRITE,
    output logic [2:0]                           HSIZE,
    output logic [2:0]                           HBURST,
    output logic [3:0]                           HPROT,
    output logic [1:0]                           HTRANS,
    output logic                                 HMASTLOCK,
    input  logic                                 HREADY,
    input  logic                                 HRESP,

    output logic                                 busy_o,
    output logic                                 err_o,
    output logic [PLEN-1:0]                      err_adr_o
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam int SIZE_LSB = entry_size_lsb(XLEN);
    localparam int ADR_LSB  = entry_adr_lsb(XLEN);

    state_t            state_reg;
    logic [PLEN-1:0]   adr_reg;
    logic [2:0]        size_reg;
    logic [XLEN-1:0]   data_reg;
    logic              err_reg;
    logic [PLEN-1:0]   err_adr_reg;
    logic              clr_pend_reg;

    logic [PLEN-1:0]   q_adr;
    logic [2:0]        q_size;
    logic [XLEN-1:0]   q_data;

    logic              hresp_err;
    logic              abort;
    logic              addr_issue;
    logic              addr_accept;
    logic              data_done;

    assign q_data = q_i[ENTRY_DATA_LSB +: XLEN];
    assign q_size = q_i[SIZE_LSB +: ENTRY_SIZE_W];
    assign q_adr  = q_i[ADR_LSB +: PLEN];

    assign hresp_err = (HRESP == HRESP_ERROR);
    assign abort     = clr_i | clr_pend_reg;

`ifdef PU_RISCV_WB_DRAIN_PIPELINE_EN
    // The overlapped address phase is withheld while a data phase reports ERROR,
    // so the pending entry is re-issued from ADDR once the error completes.
    assign addr_issue = ((state_reg == ADDR) && !q_empty_i && !clr_i) ||
                        ((state_reg == DATA) && !q_empty_i && !abort && !hresp_err);
`else
    assign addr_issue = (state_reg == ADDR) && !q_empty_i && !clr_i;
`endif

    assign addr_accept = addr_issue & HREADY;
    assign data_done   = (state_reg == DATA) & HREADY;

    assign q_re_o    = addr_accept;
    assign HSEL      = addr_issue;
    assign HTRANS    = addr_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = addr_issue ? q_adr  : adr_reg;
    assign HSIZE     = addr_issue ? q_size : size_reg;
    assign HWDATA    = data_reg;
    assign HWRITE    = 1'b1;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign busy_o    = (state_reg != IDLE);
    assign err_o     = err_reg;
    assign err_adr_o = err_adr_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            adr_reg      <= '0;
            size_reg     <= '0;
            data_reg     <= '0;
            err_reg      <= 1'b0;
            err_adr_reg  <= '0;
            clr_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!q_empty_i && !clr_i) begin
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (clr_i || q_empty_i) begin
                        state_reg <= IDLE;
                    end else if (HREADY) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (HREADY) begin
                        if (addr_accept) begin
                            state_reg <= DATA;
                        end else if (abort || q_empty_i) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= ADDR;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (addr_accept) begin
                adr_reg  <= q_adr;
                size_reg <= q_size;
                data_reg <= q_data;
            end

            // A clear seen during a wait state is remembered until the data phase ends.
            if (data_done) begin
                clr_pend_reg <= 1'b0;
            end else if ((state_reg == DATA) && clr_i) begin
                clr_pend_reg <= 1'b1;
            end

            if (clr_i) begin
                err_reg     <= 1'b0;
                err_adr_reg <= '0;
            end else if (data_done && hresp_err && !err_reg) begin
                err_reg     <= 1'b1;
                err_adr_reg <= adr_reg;
            end
        end
    end

endmodule

// File: tb/tb_pu_riscv_wb_drain.sv
// Directed bench for pu_riscv_wb_drain: queue model, AHB write monitor, immediate-assert checks.
// Follows PU_RISCV_WB_DRAIN_PIPELINE_EN for the mode-dependent expectations.
module tb_pu_riscv_wb_drain;

    localparam int PLEN = 32;
    localparam int XLEN = 64;
    localparam int EW   = PLEN + 3 + XLEN;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              clr_i;
    logic [EW-1:0]     q_i;
    logic              q_empty_i;
    logic              q_re_o;
    logic              HSEL;
    logic [PLEN-1:0]   HADDR;
    logic [XLEN-1:0]   HWDATA;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic              HMASTLOCK;
    logic              HREADY;
    logic              HRESP;
    logic              busy_o;
    logic              err_o;
    logic [PLEN-1:0]   err_adr_o;

    pu_riscv_wb_drain #(.PLEN(PLEN), .XLEN(XLEN), .HPROT_VAL(4'b0001)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .q_i(q_i), .q_empty_i(q_empty_i), .q_re_o(q_re_o),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .busy_o(busy_o), .err_o(err_o), .err_adr_o(err_adr_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-buffer model feeding the DUT
    logic [PLEN-1:0] mem_adr  [32];
    logic [2:0]      mem_size [32];
    logic [XLEN-1:0] mem_data [32];
    int head = 0;
    int tail = 0;

    task automatic drive_q();
        q_empty_i = (head == tail);
        q_i = {mem_adr[head], mem_size[head], mem_data[head]};
    endtask

    task automatic push(input logic [PLEN-1:0] adr, input logic [2:0] size, input logic [XLEN-1:0] data);
        mem_adr[tail]  = adr;
        mem_size[tail] = size;
        mem_data[tail] = data;
        tail++;
        drive_q();
        #1;
    endtask

    task automatic cyc();
        logic pop;
        pop = q_re_o;
        @(posedge clk_i);
        #1;
        if (pop) head++;
        drive_q();
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, busy_o, 1'b0);
    endtask

    // AHB monitor: one line per completed write data phase
    int              wr_cnt = 0;
    logic [PLEN-1:0] wr_adr  [64];
    logic [XLEN-1:0] wr_data [64];
    logic            wr_resp [64];
    logic            dp_valid = 1'b0;
    logic [PLEN-1:0] dp_adr   = '0;
    int              viol     = 0;

    always @(posedge clk_i) begin
        if (q_re_o && q_empty_i) viol <= viol + 1;
        if (!rst_ni) begin
            dp_valid <= 1'b0;
        end else if (HREADY) begin
            if (dp_valid) begin
                wr_adr[wr_cnt]  <= dp_adr;
                wr_data[wr_cnt] <= HWDATA;
                wr_resp[wr_cnt] <= HRESP;
                wr_cnt          <= wr_cnt + 1;
                $display("write adr=%08h data=%016h resp=%0d", dp_adr, HWDATA, HRESP);
            end
            dp_valid <= HSEL && (HTRANS == 2'b10);
            dp_adr   <= HADDR;
        end
    end

    initial begin
        int w0, h0, cyc_n, pops, mask;
        for (int i = 0; i < 32; i++) begin
            mem_adr[i] = '0; mem_size[i] = '0; mem_data[i] = '0;
        end
        rst_ni = 1'b0; clr_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        drive_q();
        repeat (3) @(posedge clk_i);
        #1;

        // Reset state
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSEL, 1'b0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 64'h0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_qre", q_re_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_erradr", err_adr_o, 32'h0);
        chk("const_hwrite", HWRITE, 1'b1);
        chk("const_hburst", HBURST, 3'b000);
        chk("const_hprot", HPROT, 4'b0001);
        chk("const_hlock", HMASTLOCK, 1'b0);
        rst_ni = 1'b1;
        cyc();

        // Single entry
        w0 = wr_cnt;
        push(32'h0000_1000, 3'd3, 64'hDEAD_BEEF_0123_4567);
        cyc();
        chk("s_htrans", HTRANS, 2'b10);
        chk("s_haddr", HADDR, 32'h0000_1000);
        chk("s_hsel", HSEL, 1'b1);
        chk("s_hsize", HSIZE, 3'd3);
        chk("s_qre", q_re_o, 1'b1);
        chk("s_busy_a", busy_o, 1'b1);
        cyc();
        chk("s_hwdata", HWDATA, 64'hDEAD_BEEF_0123_4567);
        chk("s_htrans_d", HTRANS, 2'b00);
        chk("s_qre_d", q_re_o, 1'b0);
        cyc();
        chk("s_busy_i", busy_o, 1'b0);
        chk("s_haddr_hold", HADDR, 32'h0000_1000);
        chk("s_hsize_hold", HSIZE, 3'd3);
        chk("s_wr_cnt", wr_cnt - w0, 1);
        chk("s_wr_data", wr_data[w0], 64'hDEAD_BEEF_0123_4567);

        // Four back-to-back entries, zero wait states
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++)
            push(32'h100 + 32'(i * 8), 3'd3, 64'h1111_0000_0000_0000 + 64'(i));
        cyc();
        cyc_n = 0; pops = 0; mask = 0;
        while (busy_o && cyc_n < 20) begin
            cyc_n++;
            if (q_re_o) begin
                pops++;
                mask |= 1 << (cyc_n - 1);
            end
            cyc();
        end
`ifdef PU_RISCV_WB_DRAIN_PIPELINE_EN
        chk("b4_cycles", cyc_n, 5);
        chk("b4_popmask", mask, 32'h0F);
`else
        chk("b4_cycles", cyc_n, 8);
        chk("b4_popmask", mask, 32'h55);
`endif
        chk("b4_pops", pops, 4);
        chk("b4_wr_cnt", wr_cnt - w0, 4);
        chk("b4_last_adr", wr_adr[w0 + 3], 32'h118);
        chk("b4_last_data", wr_data[w0 + 3], 64'h1111_0000_0000_0003);

        // Three wait states in the data phase
        w0 = wr_cnt;
        push(32'h3000, 3'd2, 64'hAAAA_5555_AAAA_5555);
        push(32'h3008, 3'd2, 64'h0BAD_F00D_CAFE_0001);
        cyc();
        chk("w_qre_a", q_re_o, 1'b1);
        cyc();
        HREADY = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("w_hwdata", HWDATA, 64'hAAAA_5555_AAAA_5555);
            chk("w_qre_wait", q_re_o, 1'b0);
            cyc();
        end
        HREADY = 1'b1;
        #1;
        chk("w_hwdata_last", HWDATA, 64'hAAAA_5555_AAAA_5555);
`ifdef PU_RISCV_WB_DRAIN_PIPELINE_EN
        chk("w_qre_done", q_re_o, 1'b1);
`else
        chk("w_qre_done", q_re_o, 1'b0);
`endif
        cyc();
        drain("w_drain");
        chk("w_wr_cnt", wr_cnt - w0, 2);
        chk("w_wr_adr1", wr_adr[w0 + 1], 32'h3008);
        chk("w_wr_data1", wr_data[w0 + 1], 64'h0BAD_F00D_CAFE_0001);

        // Two-cycle ERROR response, drain continues
        w0 = wr_cnt;
        push(32'h2000, 3'd3, 64'hE000_0000_0000_0001);
        push(32'h2008, 3'd3, 64'hE000_0000_0000_0002);
        cyc();
        chk("e_haddr", HADDR, 32'h2000);
        cyc();
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        chk("e_htrans1", HTRANS, 2'b00);
        chk("e_err_pre", err_o, 1'b0);
        cyc();
        HREADY = 1'b1;
        #1;
        chk("e_htrans2", HTRANS, 2'b00);
        chk("e_qre2", q_re_o, 1'b0);
        cyc();
        HRESP = 1'b0;
        #1;
        chk("e_err", err_o, 1'b1);
        chk("e_erradr", err_adr_o, 32'h2000);
        chk("e_next_htrans", HTRANS, 2'b10);
        chk("e_next_haddr", HADDR, 32'h2008);
        drain("e_drain");
        chk("e_wr_cnt", wr_cnt - w0, 2);
        chk("e_wr_resp0", wr_resp[w0], 1'b1);
        chk("e_wr_adr1", wr_adr[w0 + 1], 32'h2008);
        chk("e_wr_resp1", wr_resp[w0 + 1], 1'b0);

        // Second error keeps the first address
        push(32'h2010, 3'd3, 64'hE000_0000_0000_0003);
        cyc();
        cyc();
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        cyc();
        HREADY = 1'b1;
        #1;
        cyc();
        HRESP = 1'b0;
        #1;
        chk("e2_err", err_o, 1'b1);
        chk("e2_erradr", err_adr_o, 32'h2000);
        drain("e2_drain");

        // Clear during a data-phase wait state
        w0 = wr_cnt;
        h0 = head;
        push(32'h4000, 3'd1, 64'h4444_0000_0000_0000);
        push(32'h4008, 3'd1, 64'h4444_0000_0000_0001);
        push(32'h4010, 3'd1, 64'h4444_0000_0000_0002);
        cyc();
        cyc();
        HREADY = 1'b0; clr_i = 1'b1;
        #1;
        chk("c_htrans", HTRANS, 2'b00);
        chk("c_hwdata", HWDATA, 64'h4444_0000_0000_0000);
        cyc();
        chk("c_err_clr", err_o, 1'b0);
        chk("c_busy", busy_o, 1'b1);
        chk("c_hwdata_hold", HWDATA, 64'h4444_0000_0000_0000);
        HREADY = 1'b1;
        #1;
        chk("c_qre", q_re_o, 1'b0);
        chk("c_htrans_done", HTRANS, 2'b00);
        cyc();
        chk("c_idle", busy_o, 1'b0);
        cyc();
        chk("c_idle2", busy_o, 1'b0);
        chk("c_pops", head - h0, 1);
        chk("c_wr_cnt", wr_cnt - w0, 1);
        head = tail;
        drive_q();
        clr_i = 1'b0;
        cyc();

        // Reset asserted during the address phase
        push(32'h5000, 3'd3, 64'h5555_5555_5555_5555);
        cyc();
        chk("r_htrans_a", HTRANS, 2'b10);
        rst_ni = 1'b0;
        #1;
        chk("r_htrans", HTRANS, 2'b00);
        chk("r_hsel", HSEL, 1'b0);
        chk("r_haddr", HADDR, 32'h0);
        chk("r_hwdata", HWDATA, 64'h0);
        chk("r_hsize", HSIZE, 3'd0);
        chk("r_qre", q_re_o, 1'b0);
        chk("r_busy", busy_o, 1'b0);
        h0 = head;
        cyc();
        cyc();
        chk("r_no_pop", head - h0, 0);
        head = tail;
        drive_q();
        rst_ni = 1'b1;
        cyc();
        chk("r_idle", busy_o, 1'b0);

        chk("qre_while_empty", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pu_riscv_wb_drain.md
PU_RISCV_WB_DRAIN -- requirements
Module: pu_riscv_wb_drain

Interface
REQ-001 SHALL have parameter PLEN, default 32, physical address width.
REQ-002 SHALL have parameter XLEN, default 64, data width.
REQ-003 SHALL have parameter HPROT_VAL, default 4'b0001, constant HPROT value.
REQ-004 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr_i, input, 1, synchronous abort of pending, unaccepted work.
REQ-007 SHALL have port q_i, input, PLEN+3+XLEN, queue head {adr, size, data}.
REQ-008 SHALL have port q_empty_i, input, 1, queue empty flag.
REQ-009 SHALL have port q_re_o, output, 1, queue pop, one cycle per entry.
REQ-010 SHALL have ports HSEL, HADDR[PLEN], HWDATA[XLEN], HWRITE, HSIZE[3], HBURST[3], HPROT[4], HTRANS[2], HMASTLOCK as outputs; HREADY, HRESP as inputs (AHB3-Lite master).
REQ-011 SHALL have outputs busy_o (1, transfer pending or in flight), err_o (1, sticky bus error), err_adr_o (PLEN, failing address).

Function
REQ-012 SHALL drain queue entries as single AHB write transfers: HWRITE=1, HBURST=SINGLE, HMASTLOCK=0, HPROT=HPROT_VAL, HSIZE=entry size.
REQ-013 SHALL use FSM states IDLE, ADDR, DATA.
REQ-014 IDLE->ADDR when !q_empty_i and !clr_i; ADDR drives HTRANS=NONSEQ, HSEL=1, HADDR=entry adr, combinationally from q_i.
REQ-015 Address phase accepted on HREADY=1 in ADDR: same cycle q_re_o=1, entry data and adr latched; next state DATA.
REQ-016 DATA drives HWDATA from latched data, held stable until HREADY=1.
REQ-017 DATA with HREADY=1: transfer complete; next state ADDR if queue non-empty, else IDLE.
REQ-018 HTRANS SHALL be IDLE in every non-ADDR cycle; HADDR/HSIZE hold last value when idle.
REQ-019 HRESP=ERROR in DATA: first (HREADY=0) cycle drives HTRANS=IDLE; on completion err_o<=1, err_adr_o<=latched adr; drain continues with next entry.
REQ-020 err_o SHALL remain set until reset or clr_i; multiple errors keep first err_adr_o.
REQ-021 clr_i in IDLE/ADDR: return to IDLE, no pop, no transfer; in DATA: current data phase completes (HWDATA held), then IDLE.
REQ-022 q_re_o SHALL never assert while q_empty_i=1.
REQ-023 busy_o=1 in ADDR and DATA, 0 in IDLE.

Reset
REQ-024 On rst_ni low: state IDLE, HTRANS=IDLE, HSEL=0, HADDR=0, HWDATA=0, HSIZE=0, q_re_o=0, busy_o=0, err_o=0, err_adr_o=0.
REQ-025 Reset mid-transfer SHALL abandon transfer immediately; no pop occurs.

Configuration
REQ-026 Macro PU_RISCV_WB_DRAIN_PIPELINE_EN SHALL enable address/data overlap.
REQ-027 With macro: in DATA, if !q_empty_i, next address phase (NONSEQ) is driven concurrently; on HREADY=1 both complete and pop occurs; sustained throughput 1 entry/cycle with zero wait states; ERROR first cycle forces HTRANS=IDLE and re-issues the pending entry afterward (no pop).
REQ-028 Without macro: strict ADDR/DATA alternation, 2 cycles per entry minimum.

Structure
REQ-029 Shared package pu_riscv_pkg SHALL hold HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE encodings, HRESP_OKAY/ERROR, and entry field offset constants.
REQ-030 Block SHALL be one module; no sub-modules; FSM state typedef local to module.

Verification
REQ-031 One entry {adr=0x0000_1000, size=3, data=0xDEAD_BEEF_0123_4567}, HREADY=1 -> NONSEQ cycle 1 with HADDR 0x1000, q_re_o pulse, HWDATA 0xDEAD_BEEF_0123_4567 cycle 2, then IDLE, busy_o=0.
REQ-032 Four entries, HREADY=1, macro off -> 8 cycles, 4 pops; macro on -> 5 cycles, pops on cycles 1-4.
REQ-033 HREADY low 3 cycles in DATA -> HWDATA stable for 4 cycles, no second pop.
REQ-034 Two-cycle ERROR on adr 0x2000 -> err_o=1, err_adr_o=0x2000, next entry still written.
REQ-035 clr_i during DATA wait state -> data phase completes, then IDLE, remaining entries untouched, err_o cleared.
REQ-036 rst_ni asserted in ADDR -> all outputs at reset values asynchronously, q_re_o never pulsed.
